// File: rtl/counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module      : counter_mod_updown
// Description : Loadable up/down modulus counter with prescaler, wrap/saturate
//               mode, terminal-count pulse, sticky overflow and gated output.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_mod_updown #(
   parameter int               WIDTH     = 8,
   parameter int               PRESC_W   = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               load,
   input  logic               clr,
   input  logic               up,
   input  logic               sat,
   input  logic               oe,
   input  logic [PRESC_W-1:0] div,
   input  logic [WIDTH-1:0]   lim,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   y,
   output logic               tc,
   output logic               ovf
);

   logic [WIDTH-1:0]   count_q;
   logic [PRESC_W-1:0] presc_q;
   logic               tc_q;
   logic               ovf_q;

   logic               step;
   logic               at_bound;
   logic               bound_step;
   logic [WIDTH-1:0]   next_count;

   assign step       = en && (presc_q >= div);
   assign at_bound   = up ? (count_q >= lim) : (count_q == '0);
   assign bound_step = step && at_bound;

   // A value loaded above lim counts as a boundary going up, but steps down normally.
   always_comb begin
      next_count = count_q;
      if (up) begin
         if (at_bound) next_count = sat ? count_q : '0;
         else          next_count = count_q + 1'b1;
      end else begin
         if (at_bound) next_count = sat ? '0 : lim;
         else          next_count = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RESET_VAL;
         presc_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load) begin
         count_q <= d;
         presc_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (clr) begin
         count_q <= '0;
         presc_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // presc_q < div whenever no step is taken, so the increment cannot wrap.
         if (en) presc_q <= step ? '0 : presc_q + 1'b1;
         if (step) count_q <= next_count;
         tc_q  <= bound_step;
         ovf_q <= ovf_q | bound_step;
      end
   end

   assign y   = oe ? count_q : '0;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_mod_updown
// Description : Self-checking bench for counter_mod_updown using directed and
//               randomized stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_mod_updown;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 4;
   localparam int MODV    = 1 << WIDTH;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               en, load, clr, up, sat, oe;
   logic [PRESC_W-1:0] div;
   logic [WIDTH-1:0]   lim, d;
   logic [WIDTH-1:0]   y;
   logic               tc, ovf;

   int checks = 0;
   int errors = 0;

   // Reference state: counter value, enabled-cycle phase, flags.
   int m_cnt, m_ph, m_tc, m_ovf;

   counter_mod_updown #(.WIDTH(WIDTH), .PRESC_W(PRESC_W), .RESET_VAL('0)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .clr(clr),
      .up(up), .sat(sat), .oe(oe), .div(div), .lim(lim), .d(d),
      .y(y), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_ph = 0; m_tc = 0; m_ovf = 0;
   endtask

   // One clock edge of the specified behaviour, evaluated with plain integers.
   task automatic model_edge();
      int l, div_i;
      l = int'(lim);
      div_i = int'(div);
      m_tc = 0;
      if (load) begin
         m_cnt = int'(d); m_ph = 0; m_ovf = 0;
      end else if (clr) begin
         m_cnt = 0; m_ph = 0; m_ovf = 0;
      end else if (en) begin
         if (m_ph >= div_i) begin
            m_ph = 0;
            if (up) begin
               if (m_cnt >= l) begin m_tc = 1; if (!sat) m_cnt = 0; end
               else m_cnt = (m_cnt + 1) % MODV;
            end else begin
               if (m_cnt == 0) begin m_tc = 1; m_cnt = sat ? 0 : l; end
               else m_cnt = m_cnt - 1;
            end
         end else begin
            m_ph = m_ph + 1;
         end
         if (m_tc != 0) m_ovf = 1;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".y"},   int'(y),   oe ? m_cnt : 0);
      check({tag, ".tc"},  int'(tc),  m_tc);
      check({tag, ".ovf"}, int'(ovf), m_ovf);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic set_idle();
      en = 0; load = 0; clr = 0; up = 1; sat = 0; oe = 1;
      div = '0; lim = 8'hFF; d = '0;
   endtask

   task automatic async_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      check({tag, ".y"},   int'(y),   0);
      check({tag, ".tc"},  int'(tc),  0);
      check({tag, ".ovf"}, int'(ovf), 0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   int wrap_exp [7] = '{1, 2, 3, 4, 5, 0, 1};
   int satd_exp [4] = '{1, 0, 0, 0};

   initial begin
      set_idle();
      reset_n = 1'b0;
      model_reset();
      #12;
      reset_n = 1'b1;
      check("reset.y", int'(y), 0);

      // Reset taken mid-count
      en = 1; div = 0; lim = 8'hFF;
      for (int i = 0; i < 5; i++) tick("run");
      async_reset("rst_mid");
      en = 0;
      for (int i = 0; i < 2; i++) tick("rst_hold");
      check("rst_hold.y0", int'(y), 0);

      // Wrap up at lim=5
      lim = 8'd5; en = 1; up = 1; sat = 0; div = 0;
      for (int i = 0; i < 7; i++) begin
         tick("wrap");
         check("wrap.seq", int'(y), wrap_exp[i]);
         check("wrap.tc", int'(tc), (i == 5) ? 1 : 0);
      end
      check("wrap.ovf", int'(ovf), 1);

      // Saturate down from 2
      load = 1; d = 8'd2; up = 0; sat = 1;
      tick("satd.load");
      check("satd.y2", int'(y), 2);
      load = 0;
      for (int i = 0; i < 4; i++) begin
         tick("satd");
         check("satd.seq", int'(y), satd_exp[i]);
         check("satd.tc", int'(tc), (i >= 2) ? 1 : 0);
      end
      clr = 1;
      tick("satd.clr");
      check("satd.clr_ovf", int'(ovf), 0);
      clr = 0;

      // Prescaler divide-by-3 with an enable gap
      up = 1; sat = 0; lim = 8'hFF; div = 2; en = 1;
      for (int i = 0; i < 7; i++) tick("presc");
      check("presc.y", int'(y), 2);
      en = 0;
      for (int i = 0; i < 4; i++) tick("presc.hold");
      check("presc.hold_y", int'(y), 2);
      en = 1;
      for (int i = 0; i < 3; i++) tick("presc.resume");
      check("presc.resume_y", int'(y), 3);

      // load beats clr beats step
      load = 1; clr = 1; d = 8'hA7; div = 0;
      tick("prio");
      check("prio.y", int'(y), 8'hA7);
      check("prio.ovf", int'(ovf), 0);
      load = 0; clr = 0; lim = 8'h10; up = 1; sat = 0;
      tick("prio.wrap");
      check("prio.wrap_y", int'(y), 0);
      check("prio.wrap_tc", int'(tc), 1);

      // oe gating while the count keeps advancing
      oe = 0; lim = 8'hFF;
      for (int i = 0; i < 3; i++) tick("oe_off");
      oe = 1;
      #1;
      check("oe_on.y", int'(y), 3);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(0, 9) < 8);
         load = ($urandom_range(0, 39) == 0);
         clr  = ($urandom_range(0, 39) == 0);
         d    = WIDTH'($urandom);
         oe   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) up  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 29) == 0) sat = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 49) == 0) div = PRESC_W'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) begin
            case ($urandom_range(0, 3))
               0:       lim = '0;
               1:       lim = 8'hFF;
               default: lim = WIDTH'($urandom_range(1, 20));
            endcase
         end
         if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
         else tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
